mips_muldiv: RTL

MIPS_MULDIV -- requirements
Module: mips_muldiv

---
 rtl/mips_muldiv_pkg.sv | 27 ++
 rtl/mips_muldiv_step.sv | 50 +++++
 rtl/mips_muldiv.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: operation encoding,
// controller state type and default datapath width.
package mips_muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Operation encoding as presented on the op port
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the iterative datapath: a shift-add multiply step or a
// restoring shift-subtract divide step on unsigned magnitudes.
//   multiply: {acc_hi,acc_lo} = partial product / remaining multiplier bits,
//             opnd = multiplicand
//   divide:   acc_hi = partial remainder, acc_lo = dividend bits / quotient,
//             opnd = divisor
module mips_muldiv_step
  #(parameter int WIDTH = 32)
  (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
  );

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Single combinational step for either operation class
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    next_hi = acc_hi;
    next_lo = acc_lo;
    sum     = {1'b0, acc_hi} + {1'b0, opnd};
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    // The true difference is below the divisor whenever it is used, so the
    // low WIDTH bits carry it exactly.
    diff    = shifted[WIDTH-1:0] - opnd;
    if (is_div) begin
      if (shifted >= {1'b0, opnd}) begin
        next_hi = diff;
        next_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        next_hi = shifted[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_lo[0]) begin
        {next_hi, next_lo} = {sum, acc_lo[WIDTH-1:1]};
      end else begin
        {next_hi, next_lo} = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mips_muldiv.sv
// MIPS HI/LO multiply/divide unit. IDLE -> RUN (WIDTH iterations) -> FIX
// (sign correction, HI/LO write, done pulse) -> IDLE.
// Optional build macro MIPS_MULDIV_FAST_MUL_EN: MULT/MULTU use a single-cycle
// array multiply and skip RUN; divides stay iterative.
module mips_muldiv
  import mips_muldiv_pkg::*;
  #(parameter int WIDTH = DEFAULT_WIDTH)
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
  );

`ifdef MIPS_MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] rs_r, rt_r;
  logic [WIDTH-1:0] w_hi, w_lo, opnd_r;
  logic [WIDTH-1:0] step_hi, step_lo;

  logic             in_div, in_sgn;
  logic [WIDTH-1:0] in_a_mag, in_b_mag;
  logic             r_div, r_sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_mag;
  logic [WIDTH-1:0] res_hi, res_lo;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                           input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign busy = (state != ST_IDLE);

  mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (r_div),
    .acc_hi  (w_hi),
    .acc_lo  (w_lo),
    .opnd    (opnd_r),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // Operand magnitudes for the incoming request and the latched request
  always_comb begin
    in_div   = op_is_div(op);
    in_sgn   = op_is_signed(op);
    in_a_mag = mag(rs_val, in_sgn);
    in_b_mag = mag(rt_val, in_sgn);
    r_div    = op_is_div(op_r);
    r_sgn    = op_is_signed(op_r);
    a_mag    = mag(rs_r, r_sgn);
    b_mag    = mag(rt_r, r_sgn);
  end

  // Final result: sign correction and divide-by-zero override
  always_comb begin
    res_hi   = w_hi;
    res_lo   = w_lo;
    prod_mag = {w_hi, w_lo};
    if (FAST_MUL) begin
      prod_mag = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    end
    if (!r_div) begin
      if (r_sgn && (rs_r[WIDTH-1] ^ rt_r[WIDTH-1])) begin
        {res_hi, res_lo} = -prod_mag;
      end else begin
        {res_hi, res_lo} = prod_mag;
      end
    end else if (rt_r == '0) begin
      // Architectural divide-by-zero result, independent of signedness
      res_hi = rs_r;
      res_lo = '1;
    end else begin
      // Quotient truncates toward zero; remainder follows the dividend sign
      if (r_sgn && (rs_r[WIDTH-1] ^ rt_r[WIDTH-1])) res_lo = -w_lo;
      if (r_sgn && rs_r[WIDTH-1])                  res_hi = -w_hi;
    end
  end

  // Controller, iteration counter, operand/work registers and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand and work registers are reset along with the control
    // state, so an aborted operation leaves nothing behind after reset.
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_r   <= OP_MULTU;
      rs_r   <= '0;
      rt_r   <= '0;
      w_hi   <= '0;
      w_lo   <= '0;
      opnd_r <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_r   <= op;
            rs_r   <= rs_val;
            rt_r   <= rt_val;
            cnt    <= '0;
            w_hi   <= '0;
            w_lo   <= in_div ? in_a_mag : in_b_mag;
            opnd_r <= in_div ? in_b_mag : in_a_mag;
            state  <= (FAST_MUL && !in_div) ? ST_FIX : ST_RUN;
          end
        end
        ST_RUN: begin
          w_hi <= step_hi;
          w_lo <= step_lo;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_ITER) state <= ST_FIX;
        end
        ST_FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
